pdl_puf_array_ctrl: RTL and testbench



---
 rtl/pdl_puf_array_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pdl_puf_array_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pdl_puf_array_ctrl.sv
// Evaluation controller for an array of PDL arbiter PUFs: shared challenge/launch,
// per-channel majority vote and stability flag. Optional auto-tune: PDL_PUF_AUTOTUNE_EN.
module pdl_puf_array_ctrl #(
    parameter int N_CB   = 64,
    parameter int N      = 16,
    parameter int N_CH   = 4,
    parameter int N_EVAL = 16,
    parameter int SETTLE = 4,
    parameter int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_CB-1:0]   challenge_in,
    input  logic              tune_we,
    input  logic [CHW-1:0]    tune_ch,
    input  logic [N-1:0]      tune_data,
    input  logic [N_CH-1:0]   puf_out,
    output logic              puf_in,
    output logic [N_CB-1:0]   puf_challenge,
    output logic [N_CH*N-1:0] puf_tune,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   response,
    output logic [N_CH-1:0]   stable
);

    localparam int CW = $clog2(N_EVAL + 1);
    localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(N_EVAL);
    localparam logic [CW-1:0]  CNT_HALF = CW'(N_EVAL / 2);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [PW-1:0]  PH_LAST  = PW'(SETTLE - 1);
    localparam logic [PW-1:0]  PH_ONE   = PW'(1);
    localparam logic [PW-1:0]  PH_ZERO  = PW'(0);
    localparam logic [N-1:0]   TUNE_MID = {{(N - N/2){1'b0}}, {(N/2){1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RELAX  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     phase_r;
    logic [CW-1:0]     eval_r;
    logic [CW-1:0]     cnt_r [N_CH];
    logic [N_CH-1:0]   sync1_r;
    logic [N_CH-1:0]   sync2_r;

`ifdef PDL_PUF_AUTOTUNE_EN
    // Thermometer step towards less delay: shift right, 0 enters at MSB, sticks at 0.
    function automatic logic [N-1:0] thermo_down(input logic [N-1:0] w);
        return {1'b0, w[N-1:1]};
    endfunction

    // Thermometer step towards more delay: shift left, 1 enters at LSB, sticks at all-ones.
    function automatic logic [N-1:0] thermo_up(input logic [N-1:0] w);
        return {w[N-2:0], 1'b1};
    endfunction
`endif

    // Two-flop synchroniser for the asynchronous arbiter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N_CH{1'b0}};
            sync2_r <= {N_CH{1'b0}};
        end else begin
            sync1_r <= puf_out;
            sync2_r <= sync1_r;
        end
    end

    // Evaluation sequencer with all outputs registered; tune words owned here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            phase_r       <= PH_ZERO;
            eval_r        <= CNT_ZERO;
            puf_in        <= 1'b0;
            puf_challenge <= {N_CB{1'b0}};
            puf_tune      <= {N_CH{TUNE_MID}};
            busy          <= 1'b0;
            done          <= 1'b0;
            response      <= {N_CH{1'b0}};
            stable        <= {N_CH{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tune_we && (int'(tune_ch) < N_CH)) begin
                        puf_tune[int'(tune_ch)*N +: N] <= tune_data;
                    end
                    if (start) begin
                        puf_challenge <= challenge_in;
                        phase_r       <= PH_ZERO;
                        eval_r        <= CNT_ZERO;
                        busy          <= 1'b1;
                        puf_in        <= 1'b0;
                        state_r       <= ST_LOAD;
                        for (int i = 0; i < N_CH; i++) begin
                            cnt_r[i] <= CNT_ZERO;
                        end
                    end
                end
                ST_LOAD: begin
                    if (phase_r == PH_LAST) begin
                        phase_r <= PH_ZERO;
                        puf_in  <= 1'b1;
                        state_r <= ST_FIRE;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                ST_FIRE: begin
                    if (phase_r == PH_LAST) begin
                        phase_r <= PH_ZERO;
                        state_r <= ST_SAMPLE;
                    end else begin
                        phase_r <= phase_r + PH_ONE;
                    end
                end
                ST_SAMPLE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (sync2_r[i] && (cnt_r[i] != CNT_FULL)) begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    eval_r  <= eval_r + CNT_ONE;
                    puf_in  <= 1'b0;
                    state_r <= ST_RELAX;
                end
                ST_RELAX: begin
                    if (phase_r != PH_LAST) begin
                        phase_r <= phase_r + PH_ONE;
                    end else if (eval_r < CNT_FULL) begin
                        phase_r <= PH_ZERO;
                        puf_in  <= 1'b1;
                        state_r <= ST_FIRE;
                    end else begin
                        phase_r <= PH_ZERO;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                        for (int i = 0; i < N_CH; i++) begin
                            response[i] <= (cnt_r[i] > CNT_HALF);
                            stable[i]   <= (cnt_r[i] == CNT_ZERO) || (cnt_r[i] == CNT_FULL);
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
`ifdef PDL_PUF_AUTOTUNE_EN
                    for (int i = 0; i < N_CH; i++) begin
                        if (cnt_r[i] == CNT_FULL) begin
                            puf_tune[i*N +: N] <= thermo_down(puf_tune[i*N +: N]);
                        end else if (cnt_r[i] == CNT_ZERO) begin
                            puf_tune[i*N +: N] <= thermo_up(puf_tune[i*N +: N]);
                        end
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                    puf_in  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdl_puf_array_ctrl.sv
// Randomised self-checking bench for pdl_puf_array_ctrl against a count-based reference model.
module tb_pdl_puf_array_ctrl;

    localparam int N_CB   = 64;
    localparam int N      = 16;
    localparam int N_CH   = 4;
    localparam int N_EVAL = 16;
    localparam int SETTLE = 4;
    localparam int DONE_AT = 1 + SETTLE + N_EVAL * (2 * SETTLE + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [N_CB-1:0]   challenge_in;
    logic              tune_we;
    logic [1:0]        tune_ch;
    logic [N-1:0]      tune_data;
    logic [N_CH-1:0]   puf_out;
    logic              puf_in;
    logic [N_CB-1:0]   puf_challenge;
    logic [N_CH*N-1:0] puf_tune;
    logic              busy;
    logic              done;
    logic [N_CH-1:0]   response;
    logic [N_CH-1:0]   stable;

    int total = 0;
    int bad   = 0;

    logic [N_CH-1:0]   pats [N_EVAL];
    logic [N_CH*N-1:0] tune_m;

    always #5 clk = ~clk;

    pdl_puf_array_ctrl #(
        .N_CB(N_CB), .N(N), .N_CH(N_CH), .N_EVAL(N_EVAL), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge_in(challenge_in),
        .tune_we(tune_we), .tune_ch(tune_ch), .tune_data(tune_data),
        .puf_out(puf_out), .puf_in(puf_in), .puf_challenge(puf_challenge),
        .puf_tune(puf_tune), .busy(busy), .done(done),
        .response(response), .stable(stable)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one evaluation; caller is at a negedge. Stimulus per evaluation comes from pats[].
    task automatic run_eval(input logic [63:0] chal, input bit inject);
        int cnt [N_CH];
        int cyc, k, done_cyc, done_cnt, w;
        logic prev_in;
        logic [N_CH-1:0] exp_r, exp_s;
        for (int c = 0; c < N_CH; c++) begin
            cnt[c] = 0;
            for (int e = 0; e < N_EVAL; e++) cnt[c] += int'(pats[e][c]);
            exp_r[c] = (cnt[c] * 2 > N_EVAL);
            exp_s[c] = (cnt[c] == 0) || (cnt[c] == N_EVAL);
        end
        start = 1'b1;
        challenge_in = chal;
        @(negedge clk);
        challenge_in = {$urandom, $urandom};
        cyc = 1; k = 0; prev_in = 1'b0; done_cyc = 0; done_cnt = 0;
        forever begin
            start = 1'b0;
            tune_we = 1'b0;
            if (puf_in && !prev_in && k < N_EVAL) begin
                puf_out = pats[k];
                k++;
            end
            prev_in = puf_in;
            if (cyc == 30) check_val("chal_mid", puf_challenge, chal);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    check_val("response", {60'd0, response}, {60'd0, exp_r});
                    check_val("stable", {60'd0, stable}, {60'd0, exp_s});
                    check_val("chal_done", puf_challenge, chal);
                    check_val("busy_done", {63'd0, busy}, 64'd1);
`ifdef PDL_PUF_AUTOTUNE_EN
                    for (int c = 0; c < N_CH; c++) begin
                        w = int'(tune_m[c*N +: N]);
                        if (cnt[c] == N_EVAL) w = w / 2;
                        else if (cnt[c] == 0) w = (w * 2 + 1) % 65536;
                        tune_m[c*N +: N] = w[N-1:0];
                    end
`endif
                end
            end
            if (done_cnt > 0 && cyc == done_cyc + 1) begin
                check_val("busy_after", {63'd0, busy}, 64'd0);
                check_val("tune_after", puf_tune, tune_m);
                break;
            end
            if (inject && (cyc == 20 || cyc == 80 || cyc == DONE_AT)) start = 1'b1;
            if (inject && (cyc == 50 || cyc == DONE_AT)) begin
                tune_we = 1'b1; tune_ch = 2'd2; tune_data = 16'hFFFF;
            end
            if (cyc >= DONE_AT + 50) break;
            @(negedge clk);
            cyc++;
        end
        check_val("done_cycle", 64'(done_cyc), 64'(DONE_AT));
        check_val("done_count", 64'(done_cnt), 64'd1);
    endtask

    task automatic write_tune(input logic [1:0] ch, input logic [N-1:0] data);
        tune_we = 1'b1; tune_ch = ch; tune_data = data;
        @(negedge clk);
        tune_we = 1'b0;
        tune_m[int'(ch)*N +: N] = data;
        check_val("tune_write", puf_tune, tune_m);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_puf_in"}, {63'd0, puf_in}, 64'd0);
        check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_done"}, {63'd0, done}, 64'd0);
        check_val({tag, "_resp"}, {60'd0, response}, 64'd0);
        check_val({tag, "_stable"}, {60'd0, stable}, 64'd0);
        check_val({tag, "_chal"}, puf_challenge, 64'd0);
        check_val({tag, "_tune"}, puf_tune, 64'h00FF_00FF_00FF_00FF);
    endtask

    task automatic fill_random();
        for (int e = 0; e < N_EVAL; e++) pats[e] = N_CH'($urandom);
    endtask

    task automatic fill_const(input logic [N_CH-1:0] v);
        for (int e = 0; e < N_EVAL; e++) pats[e] = v;
    endtask

    initial begin
        int waited;
        rst_n = 1'b0; start = 1'b0; challenge_in = '0; tune_we = 1'b0;
        tune_ch = 2'd0; tune_data = '0; puf_out = '0;
        tune_m = {N_CH{16'h00FF}};
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", {63'd0, busy}, 64'd0);

        fill_const(4'b0101);
        run_eval(64'hDEADBEEF_01234567, 1'b0);

        for (int e = 0; e < N_EVAL; e++) pats[e] = (N_CH'($urandom) & 4'hE) | N_CH'(e % 2);
        run_eval({$urandom, $urandom}, 1'b0);
        for (int e = 0; e < N_EVAL; e++) pats[e] = (N_CH'($urandom) & 4'hE) | N_CH'((e % 2 == 0) || (e == 1));
        run_eval({$urandom, $urandom}, 1'b0);

        fill_random();
        run_eval({$urandom, $urandom}, 1'b1);
        write_tune(2'd2, 16'hFFFF);
        write_tune(2'($urandom), 16'($urandom));

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_eval({$urandom, $urandom}, 1'b0);
        end

        start = 1'b1; challenge_in = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!puf_in && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("fire_reached", {63'd0, puf_in}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tune_m = {N_CH{16'h00FF}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("midrst_nodone", {63'd0, done}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", {63'd0, busy}, 64'd0);

        fill_random();
        run_eval({$urandom, $urandom}, 1'b0);
        fill_const(4'b0001);
        run_eval({$urandom, $urandom}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
